// File: rtl/vga_pkg.sv
// Shared VGA definitions: default active-area geometry, test-pattern mode
// encodings and the colour-bar palette.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_BOX   = 2'd3
    } mode_t;

    // Bar colours as {r,g,b} full-scale flags, left to right.
    localparam logic [2:0] BAR_WHITE   = 3'b111;
    localparam logic [2:0] BAR_YELLOW  = 3'b110;
    localparam logic [2:0] BAR_CYAN    = 3'b011;
    localparam logic [2:0] BAR_GREEN   = 3'b010;
    localparam logic [2:0] BAR_MAGENTA = 3'b101;
    localparam logic [2:0] BAR_RED     = 3'b100;
    localparam logic [2:0] BAR_BLUE    = 3'b001;
    localparam logic [2:0] BAR_BLACK   = 3'b000;

    function automatic logic [2:0] bar_flags(input logic [2:0] idx);
        logic [2:0] flags;
        case (idx)
            3'd0:    flags = BAR_WHITE;
            3'd1:    flags = BAR_YELLOW;
            3'd2:    flags = BAR_CYAN;
            3'd3:    flags = BAR_GREEN;
            3'd4:    flags = BAR_MAGENTA;
            3'd5:    flags = BAR_RED;
            3'd6:    flags = BAR_BLUE;
            default: flags = BAR_BLACK;
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/bitgen_box_mover.sv
// Bouncing-box position: one pixel per frame tick on each axis, reversing
// at the edges of the active area.
module bitgen_box_mover
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int BOX_SIZE = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    output logic [9:0] box_x,
    output logic [9:0] box_y
);

    logic [1:0][9:0] pos_all;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            localparam int LIMIT = (gi == 0) ? (H_ACTIVE - BOX_SIZE) : (V_ACTIVE - BOX_SIZE);
            logic [9:0] pos_reg;
            logic       dir_reg;   // 1 = moving towards LIMIT

            always_ff @(posedge clk) begin
                if (reset) begin
                    pos_reg <= 10'd0;
                    dir_reg <= 1'b1;
                end else if (step) begin
                    if (dir_reg) begin
                        if (pos_reg == 10'(LIMIT)) begin
                            dir_reg <= 1'b0;
                            pos_reg <= pos_reg - 10'd1;
                        end else begin
                            pos_reg <= pos_reg + 10'd1;
                        end
                    end else begin
                        if (pos_reg == 10'd0) begin
                            dir_reg <= 1'b1;
                            pos_reg <= pos_reg + 10'd1;
                        end else begin
                            pos_reg <= pos_reg - 10'd1;
                        end
                    end
                end
            end

            assign pos_all[gi] = pos_reg;
        end
    endgenerate

    assign box_x = pos_all[0];
    assign box_y = pos_all[1];

endmodule

// File: rtl/bitgen_pattern.sv
// Test-pattern pixel generator: solid, colour bars, checkerboard or bouncing
// box, with a frame-synchronous mode latch and registered RGB outputs.
module bitgen_pattern
    import vga_pkg::*;
#(
    parameter int COLOR_W     = 8,
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int BOX_SIZE    = 32,
    parameter int CHECK_SHIFT = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pixel_en,
    input  logic                   bright,
    input  logic [9:0]             hcount,
    input  logic [9:0]             vcount,
    input  logic [1:0]             mode_sel,
    input  logic [3*COLOR_W-1:0]   solid_rgb,
    output logic [COLOR_W-1:0]     vga_r,
    output logic [COLOR_W-1:0]     vga_g,
    output logic [COLOR_W-1:0]     vga_b,
    output logic                   frame_start
);

    localparam int BAR_W = H_ACTIVE / 8;

    mode_t                mode_reg;
    logic                 frame_tick;
    logic [9:0]           box_x;
    logic [9:0]           box_y;
    logic [2:0]           bar_idx;
    logic [2:0]           flags;
    logic                 use_solid;
    logic                 in_box;
    logic [10:0]          h_ext;
    logic [10:0]          v_ext;
    logic [10:0]          bx_ext;
    logic [10:0]          by_ext;
    logic [3*COLOR_W-1:0] rgb_next;
    logic [3*COLOR_W-1:0] rgb_reg;
    logic                 frame_start_reg;

    // First pixel of the first blank line marks the frame boundary.
    assign frame_tick = pixel_en && (hcount == 10'd0) && (int'(vcount) == V_ACTIVE);

    bitgen_box_mover #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BOX_SIZE (BOX_SIZE)
    ) u_box_mover (
        .clk   (clk),
        .reset (reset),
        .step  (frame_tick),
        .box_x (box_x),
        .box_y (box_y)
    );

    // Widened so box_x + BOX_SIZE never wraps at the right/bottom edge.
    assign h_ext  = {1'b0, hcount};
    assign v_ext  = {1'b0, vcount};
    assign bx_ext = {1'b0, box_x};
    assign by_ext = {1'b0, box_y};
    assign in_box = (h_ext >= bx_ext) && (h_ext < bx_ext + 11'(BOX_SIZE)) &&
                    (v_ext >= by_ext) && (v_ext < by_ext + 11'(BOX_SIZE));

    always_comb begin
        flags     = 3'b000;
        use_solid = 1'b0;
        bar_idx   = 3'(int'(hcount) / BAR_W);
        case (mode_reg)
            MODE_SOLID: use_solid = 1'b1;
            MODE_BARS:  if (int'(hcount) < H_ACTIVE) flags = bar_flags(bar_idx);
            MODE_CHECK: flags = {3{hcount[CHECK_SHIFT] ^ vcount[CHECK_SHIFT]}};
            MODE_BOX:   use_solid = in_box;
            default:    flags = 3'b000;
        endcase
        if (!bright) begin
            flags     = 3'b000;
            use_solid = 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            // Channel 0 is red, held in the top slice of the packed word.
            localparam int LSB = (2 - gi) * COLOR_W;
            assign rgb_next[LSB +: COLOR_W] = use_solid ? solid_rgb[LSB +: COLOR_W]
                                                        : {COLOR_W{flags[2 - gi]}};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_reg         <= '0;
            mode_reg        <= MODE_SOLID;
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= frame_tick;
            if (pixel_en) begin
                rgb_reg <= rgb_next;
                if (frame_tick) mode_reg <= mode_t'(mode_sel);
            end
        end
    end

    assign vga_r       = rgb_reg[3*COLOR_W-1 -: COLOR_W];
    assign vga_g       = rgb_reg[2*COLOR_W-1 -: COLOR_W];
    assign vga_b       = rgb_reg[COLOR_W-1:0];
    assign frame_start = frame_start_reg;

endmodule
